hazard_ctrl_unit: RTL and testbench

//  Central pipeline sequencer for the 5-stage RISC-V core. Drives stall/flush of the IF/ID, ID/EX,
//  EX/MEM and MEM/WB registers, generates EX-stage operand forwarding selects and counts hazard

---
 rtl/core_pkg.sv | 15 +
 rtl/fwd_sel_unit.sv | 23 ++
 rtl/hazard_ctrl_unit.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared pipeline definitions: result-source and forwarding encodings, and the
// hazard sequencer state type.
package core_pkg;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;
endpackage

// File: rtl/fwd_sel_unit.sv
// EX-stage operand forwarding select for one source register.
// MEM/WB producers are checked youngest first; x0 is never forwarded.
module fwd_sel_unit
  import core_pkg::*;
(
  input  logic [4:0] i_ex_rs,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_sel
);
  logic w_mem_hit, w_wb_hit;

  assign w_mem_hit = i_mem_reg_write && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rs);
  assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_ex_rs);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit)     o_sel = FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer: stall/flush control for the 5-stage core, operand
// forwarding selects and saturating stall/redirect event counters.
module hazard_ctrl_unit
  import core_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_pc_src,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

  hz_state_e        r_state, w_nxt_state;
  logic [1:0]       r_bub, w_nxt_bub;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_mem_wait, w_load_use;
  logic             w_sif, w_sid, w_sex, w_smem, w_fid, w_fex, w_any_stall;
  logic [1:0]       w_fwd_a, w_fwd_b;

  assign w_mem_wait = dmem_req & ~dmem_ready;
  assign w_load_use = ex_reg_write && (ex_result_src == RESULT_SRC_LOAD) && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    w_sif       = 1'b0;
    w_sid       = 1'b0;
    w_sex       = 1'b0;
    w_smem      = 1'b0;
    w_fid       = 1'b0;
    w_fex       = 1'b0;
    w_nxt_state = r_state;
    w_nxt_bub   = r_bub;
    if (w_mem_wait) begin
      // Freeze everything; a pending redirect waits for the access to finish.
      {w_sif, w_sid, w_sex, w_smem} = 4'b1111;
      w_nxt_state = MEM_WAIT;
      w_nxt_bub   = 2'd0;
    end else if (ex_pc_src) begin
      w_fid       = 1'b1;
      w_fex       = 1'b1;
      w_nxt_state = RUN;
      w_nxt_bub   = 2'd0;
    end else if (r_state == LU_STALL) begin
      // EX now holds a bubble, so the load-use match cannot be relied on here.
      w_sif = 1'b1;
      w_sid = 1'b1;
      w_fex = 1'b1;
      if (r_bub <= 2'd1) begin
        w_nxt_state = RUN;
        w_nxt_bub   = 2'd0;
      end else begin
        w_nxt_bub   = r_bub - 2'd1;
      end
    end else if (w_load_use) begin
      w_sif = 1'b1;
      w_sid = 1'b1;
      w_fex = 1'b1;
      if (LU_BUBBLES > 1) begin
        w_nxt_state = LU_STALL;
        w_nxt_bub   = LU_INIT;
      end else begin
        w_nxt_state = RUN;
      end
    end else begin
      w_nxt_state = RUN;
    end
  end

  assign w_any_stall = w_sif | w_sid | w_sex | w_smem;

  fwd_sel_unit u_fwd_a (
    .i_ex_rs        (ex_rs1),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_sel          (w_fwd_a)
  );

  fwd_sel_unit u_fwd_b (
    .i_ex_rs        (ex_rs2),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_sel          (w_fwd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_bub       <= 2'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_bub   <= w_nxt_bub;
      if (w_any_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_fid && (r_flush_cnt != '1))       r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign stall_if  = w_sif  & ~rst;
  assign stall_id  = w_sid  & ~rst;
  assign stall_ex  = w_sex  & ~rst;
  assign stall_mem = w_smem & ~rst;
  assign flush_id  = w_fid  & ~rst;
  assign flush_ex  = w_fex  & ~rst;
  assign fwd_a_sel = rst ? FWD_RF : w_fwd_a;
  assign fwd_b_sel = rst ? FWD_RF : w_fwd_b;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (1 bubble/16-bit counters and
// 2 bubbles/3-bit counters) driven in lockstep and compared to a cycle model.
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_reg_write, ex_pc_src, mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
  logic [1:0] ex_result_src;

  logic       sif[2], sid[2], sex[2], smem[2], fid[2], fex[2];
  logic [1:0] fa[2], fb[2];
  logic [15:0] sc1, fc1;
  logic [2:0]  sc2, fc2;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: extra bubble cycles still owed, event counts.
  int m_rem[2];
  int m_sc[2];
  int m_fc[2];
  int LU[2]   = '{1, 2};
  int CMAX[2] = '{65535, 7};

  hazard_ctrl_unit #(.LU_BUBBLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_if(sif[0]), .stall_id(sid[0]), .stall_ex(sex[0]), .stall_mem(smem[0]),
    .flush_id(fid[0]), .flush_ex(fex[0]), .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]),
    .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_ctrl_unit #(.LU_BUBBLES(2), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_if(sif[1]), .stall_id(sid[1]), .stall_ex(sex[1]), .stall_mem(smem[1]),
    .flush_id(fid[1]), .flush_ex(fex[1]), .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]),
    .stall_cnt(sc2), .flush_cnt(fc2));

  function automatic logic load_use();
    return ex_reg_write && ex_result_src == 2'b01 && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  function automatic logic [1:0] fwd_ref(logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [41:0] obs_vec(int d);
    if (d == 0)
      return {sif[0], sid[0], sex[0], smem[0], fid[0], fex[0], fa[0], fb[0], sc1, fc1};
    return {sif[1], sid[1], sex[1], smem[1], fid[1], fex[1], fa[1], fb[1], 13'd0, sc2, 13'd0, fc2};
  endfunction

  function automatic logic [41:0] exp_vec(int d);
    logic mw, hold, front;
    mw    = dmem_req && !dmem_ready;
    hold  = !mw && !ex_pc_src && (m_rem[d] > 0 || load_use());
    front = mw || hold;
    return {front, front, mw, mw, !mw && ex_pc_src, (!mw && ex_pc_src) || hold,
            fwd_ref(ex_rs1), fwd_ref(ex_rs2), 16'(m_sc[d]), 16'(m_fc[d])};
  endfunction

  task automatic model_tick();
    for (int d = 0; d < 2; d++) begin
      logic mw, lu, stall;
      mw    = dmem_req && !dmem_ready;
      lu    = load_use();
      stall = mw || (!ex_pc_src && (m_rem[d] > 0 || lu));
      if (stall && m_sc[d] < CMAX[d]) m_sc[d]++;
      if (!mw && ex_pc_src && m_fc[d] < CMAX[d]) m_fc[d]++;
      if (mw || ex_pc_src) m_rem[d] = 0;
      else if (m_rem[d] > 0) m_rem[d]--;
      else if (lu) m_rem[d] = LU[d] - 1;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rem[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
    end
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_reg_write, ex_pc_src, mem_reg_write, wb_reg_write, dmem_req} = '0;
    dmem_ready = 1'b1;
    ex_result_src = 2'b00;
  endtask

  task automatic set_lu5();
    ex_reg_write = 1'b1; ex_result_src = 2'b01; ex_rd = 5'd5; id_rs1 = 5'd5;
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_pc_src = 1'b1;
    mem_reg_write = 1'b1; mem_rd = 5'd3; ex_rs1 = 5'd3; ex_rs2 = 5'd3;
    #2;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_vec(d) !== 42'd0) begin
        n_err++; $display("FAIL reset dut%0d got %h want 0", d, obs_vec(d));
      end
    end
    clear_inputs();
    model_reset();
    @(negedge clk); rst = 1'b0;
    advance();
  endtask

  task automatic test_load_use();
    clear_inputs(); set_lu5();
    @(negedge clk);
    n_chk++;
    if (!(sif[0] && sid[0] && fex[0] && !sex[0] && !fid[0])) begin
      n_err++; $display("FAIL lu1_stall got if=%b id=%b fex=%b want 1 1 1", sif[0], sid[0], fex[0]);
    end
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_vec(d) !== exp_vec(d)) begin
        n_err++; $display("FAIL lu_c1 dut%0d got %h want %h", d, obs_vec(d), exp_vec(d));
      end
    end
    advance();
    ex_reg_write = 1'b0; ex_result_src = 2'b00;
    @(negedge clk);
    n_chk++;
    if (!(sif[1] && sid[1] && fex[1]) || sif[0] || fex[0]) begin
      n_err++; $display("FAIL lu_c2 got d1if=%b d2if=%b want 0 1", sif[0], sif[1]);
    end
    advance();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_vec(d) !== exp_vec(d)) begin
        n_err++; $display("FAIL lu_c3 dut%0d got %h want %h", d, obs_vec(d), exp_vec(d));
      end
    end
    n_chk++;
    if (sc2 !== 3'd2 || sc1 !== 16'd1) begin
      n_err++; $display("FAIL lu_cnt got %0d/%0d want 1/2", sc1, sc2);
    end
    advance();
  endtask

  task automatic test_redirect_lu();
    clear_inputs(); set_lu5(); ex_pc_src = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_vec(d) !== exp_vec(d)) begin
        n_err++; $display("FAIL redir dut%0d got %h want %h", d, obs_vec(d), exp_vec(d));
      end
    end
    n_chk++;
    if (!(fid[0] && fex[0]) || sif[0] || sif[1]) begin
      n_err++; $display("FAIL redir_out got fid=%b fex=%b sif=%b want 1 1 0", fid[0], fex[0], sif[0]);
    end
    advance();
    clear_inputs();
    @(negedge clk);
    n_chk++;
    if (fc1 !== 16'd1 || fc2 !== 3'd1 || sif[1]) begin
      n_err++; $display("FAIL redir_cnt got %0d/%0d sif2=%b want 1/1 0", fc1, fc2, sif[1]);
    end
    advance();
  endtask

  task automatic test_mem_wait();
    clear_inputs(); dmem_req = 1'b1; dmem_ready = 1'b0; ex_pc_src = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dmem_ready = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_err++; $display("FAIL memw_c%0d dut%0d got %h want %h", c, d, obs_vec(d), exp_vec(d));
        end
      end
      n_chk++;
      if (c < 3 ? !(sif[0] && sid[0] && sex[0] && smem[0]) || fid[0] || fex[0]
                : !(fid[0] && fex[0]) || sif[0] || smem[0]) begin
        n_err++; $display("FAIL memw_out c%0d got s=%b%b%b%b f=%b%b", c, sif[0], sid[0], sex[0], smem[0], fid[0], fex[0]);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1; ex_rs1 = 5'd7;
    @(negedge clk);
    n_chk++;
    if (fa[0] !== 2'b10 || fb[0] !== 2'b00) begin
      n_err++; $display("FAIL fwd_mem got a=%b b=%b want 10 00", fa[0], fb[0]);
    end
    advance();
    mem_rd = 5'd0; ex_rs2 = 5'd0; wb_rd = 5'd0;
    @(negedge clk);
    n_chk++;
    if (fa[1] !== 2'b00 || fb[1] !== 2'b00) begin
      n_err++; $display("FAIL fwd_x0 got a=%b b=%b want 00 00", fa[1], fb[1]);
    end
    advance();
    mem_rd = 5'd9; mem_reg_write = 1'b0; wb_rd = 5'd9; ex_rs1 = 5'd9; ex_rs2 = 5'd9;
    @(negedge clk);
    n_chk++;
    if (fa[0] !== 2'b01 || fb[0] !== 2'b01) begin
      n_err++; $display("FAIL fwd_wb got a=%b b=%b want 01 01", fa[0], fb[0]);
    end
    advance();
  endtask

  task automatic test_saturation();
    clear_inputs(); dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 10; c++) advance();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_vec(d) !== exp_vec(d)) begin
        n_err++; $display("FAIL sat dut%0d got %h want %h", d, obs_vec(d), exp_vec(d));
      end
    end
    n_chk++;
    if (sc2 !== 3'h7) begin
      n_err++; $display("FAIL sat_hold got %0d want 7", sc2);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_rst_mid_stall();
    clear_inputs(); set_lu5();
    advance();
    ex_reg_write = 1'b0;
    @(negedge clk);
    n_chk++;
    if (sif[1] !== 1'b1) begin
      n_err++; $display("FAIL rst_pre got sif2=%b want 1", sif[1]);
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_vec(d) !== 42'd0) begin
        n_err++; $display("FAIL rst_mid dut%0d got %h want 0", d, obs_vec(d));
      end
    end
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_vec(d) !== exp_vec(d)) begin
        n_err++; $display("FAIL rst_run dut%0d got %h want %h", d, obs_vec(d), exp_vec(d));
      end
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom % 2); mem_reg_write = 1'($urandom % 2);
      wb_reg_write  = 1'($urandom % 2); ex_result_src = 2'($urandom % 4);
      ex_pc_src     = ($urandom % 8) == 0;
      dmem_req      = ($urandom % 3) == 0;
      dmem_ready    = 1'($urandom % 2);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_err++; $display("FAIL rnd c%0d dut%0d got %h want %h", c, d, obs_vec(d), exp_vec(d));
        end
      end
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_load_use();
    test_redirect_lu();
    test_mem_wait();
    test_forwarding();
    test_saturation();
    test_rst_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
